// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings, FSM state type and constants for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int unsigned OpW = 4;

  // Existing encodings keep their values; MUL takes the next free slot.
  typedef enum logic [OpW-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpNot = 4'd5,
    OpLsh = 4'd6,
    OpRsh = 4'd7,
    OpSlt = 4'd8,
    OpSeq = 4'd9,
    OpMul = 4'd10
  } op_mne_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } alu_state_t;

  localparam int unsigned IllegalResult = 0;

  function automatic logic op_is_cmp(logic [OpW-1:0] op);
    return (op == OpSlt) || (op == OpSeq);
  endfunction

endpackage

// File: rtl/alu_mul_serial.sv
// Serial shift-add multiplier: one partial product per cycle, W cycles per product.
module alu_mul_serial
  import alu_mc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic            run_q, run_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  acc_step;
  logic            last_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = run_q && (cnt_q == CntW'(1));

  // The final step is exposed combinationally so the consumer can load it on the W-th edge.
  assign done    = last_step;
  assign product = acc_step;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = CntW'(W);
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      if (last_step) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes, committed status flags and serial MUL.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned Ops        = 4,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           In_Valid,
  output logic           In_Ready,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic           Out_Valid,
  input  logic           Out_Ready,
  output logic [W-1:0]   Out,
  output logic           Cond,
  output logic           Carry,
  output logic           Zero,
  output logic           Err,
  output logic           Busy
);

  localparam logic [W-1:0] WVal = W'(W);

  alu_state_t     state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           cond_q, cond_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;

  logic [OpW-1:0] op_lo;
  logic           op_hi_nz;
  logic [W-1:0]   alu_res;
  logic           alu_carry;
  logic           alu_legal;
  logic           alu_is_mul;
  logic           lt;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_product;

  // Opcodes wider than the encoding space are illegal if any upper bit is set.
  if (Ops > OpW) begin : g_op_wide
    assign op_lo    = OP[OpW-1:0];
    assign op_hi_nz = |OP[Ops-1:OpW];
  end else begin : g_op_narrow
    assign op_lo    = OpW'(OP);
    assign op_hi_nz = 1'b0;
  end

  always_comb begin
    if (SIGNED_CMP) begin
      lt = $signed(InputA) < $signed(InputB);
    end else begin
      lt = InputA < InputB;
    end
  end

  always_comb begin
    alu_res    = '0;
    alu_carry  = 1'b0;
    alu_legal  = !op_hi_nz;
    alu_is_mul = 1'b0;
    case (op_lo)
      OpAdd: {alu_carry, alu_res} = {1'b0, InputA} + {1'b0, InputB};
      OpSub: begin
        alu_res   = InputA - InputB;
        alu_carry = InputA < InputB;
      end
      OpAnd: alu_res = InputA & InputB;
      OpOr:  alu_res = InputA | InputB;
      OpXor: alu_res = InputA ^ InputB;
      OpNot: alu_res = ~InputA;
      OpLsh: alu_res = (InputB >= WVal) ? '0 : (InputA << InputB);
      OpRsh: alu_res = (InputB >= WVal) ? '0 : (InputA >> InputB);
      OpSlt: alu_res = {{(W-1){1'b0}}, lt};
      OpSeq: alu_res = {{(W-1){1'b0}}, (InputA == InputB)};
      OpMul: alu_is_mul = 1'b1;
      default: alu_legal = 1'b0;
    endcase
    if (!alu_legal) begin
      alu_res    = W'(IllegalResult);
      alu_carry  = 1'b0;
      alu_is_mul = 1'b0;
    end
  end

  assign In_Ready  = (state_q == StIdle) && (!out_valid_q || Out_Ready);
  assign accept    = In_Valid && In_Ready;
  assign mul_start = accept && alu_is_mul;

  alu_mul_serial #(
    .W (W)
  ) u_mul (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (mul_start),
    .a       (InputA),
    .b       (InputB),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cond_d      = cond_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;

    if (out_valid_q && Out_Ready) begin
      out_valid_d = 1'b0;
    end

    // A commit on the same edge as a retirement overrides the drop of Out_Valid.
    if (accept && !alu_is_mul) begin
      out_d       = alu_res;
      out_valid_d = 1'b1;
      carry_d     = alu_carry;
      zero_d      = (alu_res == '0);
      err_d       = !alu_legal;
      if (alu_legal && op_is_cmp(op_lo)) begin
        cond_d = alu_res[0];
      end
    end

    if (mul_start) begin
      state_d = StMul;
    end

    if ((state_q == StMul) && mul_done) begin
      state_d     = StIdle;
      out_d       = mul_product[W-1:0];
      out_valid_d = 1'b1;
      carry_d     = |mul_product[2*W-1:W];
      zero_d      = (mul_product[W-1:0] == '0);
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cond_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cond_q      <= cond_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign Out       = out_q;
  assign Out_Valid = out_valid_q;
  assign Cond      = cond_q;
  assign Carry     = carry_q;
  assign Zero      = zero_q;
  assign Err       = err_q;
  assign Busy      = (state_q == StMul);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: unsigned and signed-compare instances driven in lockstep.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       In_Valid;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic       Out_Ready;

  logic       rdy0, ov0, cond0, carry0, zero0, err0, busy0;
  logic [7:0] out0;
  logic       rdy1, ov1, cond1, carry1, zero1, err1, busy1;
  logic [7:0] out1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] out0;
    logic [7:0] out1;
    logic       carry;
    logic       zero0;
    logic       zero1;
    logic       err;
    logic       cond0;
    logic       cond1;
  } exp_t;

  exp_t sb[$];
  logic cm0 = 1'b0;
  logic cm1 = 1'b0;

  alu_mc #(.W(8), .Ops(4), .SIGNED_CMP(1'b0)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(rdy0),
    .InputA(InputA), .InputB(InputB), .OP(OP), .Out_Valid(ov0), .Out_Ready(Out_Ready),
    .Out(out0), .Cond(cond0), .Carry(carry0), .Zero(zero0), .Err(err0), .Busy(busy0)
  );

  alu_mc #(.W(8), .Ops(4), .SIGNED_CMP(1'b1)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(rdy1),
    .InputA(InputA), .InputB(InputB), .OP(OP), .Out_Valid(ov1), .Out_Ready(Out_Ready),
    .Out(out1), .Cond(cond1), .Carry(carry1), .Zero(zero1), .Err(err1), .Busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, result} for W=8.
  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input bit sgn);
    logic [15:0] p;
    logic        l;
    case (op)
      OpAdd: return {1'b0, a} + {1'b0, b};
      OpSub: return {(a < b), 8'(a - b)};
      OpAnd: return {1'b0, a & b};
      OpOr:  return {1'b0, a | b};
      OpXor: return {1'b0, a ^ b};
      OpNot: return {1'b0, ~a};
      OpLsh: return {1'b0, (b >= 8'd8) ? 8'h00 : 8'(a << b)};
      OpRsh: return {1'b0, (b >= 8'd8) ? 8'h00 : 8'(a >> b)};
      OpSlt: begin
        l = sgn ? ($signed(a) < $signed(b)) : (a < b);
        return {1'b0, 7'd0, l};
      end
      OpSeq: return {1'b0, 7'd0, (a == b)};
      OpMul: begin
        p = 16'(a) * 16'(b);
        return {|p[15:8], p[7:0]};
      end
      default: return 9'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] r0;
    logic [8:0] r1;
    logic       legal;
    for (int n = 0; n < 50 && !rdy0; n++) begin
      @(posedge Clk); #1;
    end
    chk("in_ready_wait", {31'd0, rdy0}, 32'd1);
    legal = (op <= 4'(OpMul));
    r0 = model(op, a, b, 1'b0);
    r1 = model(op, a, b, 1'b1);
    if (legal && (op == 4'(OpSlt) || op == 4'(OpSeq))) begin
      cm0 = r0[0];
      cm1 = r1[0];
    end
    e.out0  = legal ? r0[7:0] : 8'h00;
    e.out1  = legal ? r1[7:0] : 8'h00;
    e.carry = legal ? r0[8] : 1'b0;
    e.zero0 = (e.out0 == 8'h00);
    e.zero1 = (e.out1 == 8'h00);
    e.err   = !legal;
    e.cond0 = cm0;
    e.cond1 = cm1;
    sb.push_back(e);
    In_Valid = 1'b1;
    OP       = op;
    InputA   = a;
    InputB   = b;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    InputA   = 8'hxx;
    InputB   = 8'hxx;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  // Scoreboard pop on every output handshake.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && ov0 && Out_Ready) begin
      chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_u", {24'd0, out0}, {24'd0, e.out0});
        chk("out_s", {24'd0, out1}, {24'd0, e.out1});
        chk("carry", {30'd0, carry1, carry0}, {30'd0, e.carry, e.carry});
        chk("zero", {30'd0, zero1, zero0}, {30'd0, e.zero1, e.zero0});
        chk("err", {30'd0, err1, err0}, {30'd0, e.err, e.err});
        chk("cond", {30'd0, cond1, cond0}, {30'd0, e.cond1, e.cond0});
        chk("valid_s", {31'd0, ov1}, 32'd1);
      end
    end
  end

  initial begin
    Reset_n   = 1'b0;
    In_Valid  = 1'b0;
    InputA    = 8'h00;
    InputB    = 8'h00;
    OP        = 4'h0;
    Out_Ready = 1'b1;
    step(2);
    Reset_n = 1'b1;
    chk("rst_flags", {24'd0, ov0, cond0, carry0, zero0, err0, busy0, cond1, rdy0},
        32'h0000_0001);
    chk("rst_out", {24'd0, out0}, 32'd0);

    issue(OpAdd, 8'hF0, 8'h20);
    chk("add_out", {24'd0, out0}, 32'h10);
    chk("add_flags", {28'd0, ov0, carry0, zero0, cond0}, 32'b1100);

    issue(OpSub, 8'h05, 8'h05);
    chk("sub_flags", {29'd0, carry0, zero0, out0 == 8'h00}, 32'b011);
    issue(OpSlt, 8'h80, 8'h01);
    chk("slt_u", {30'd0, cond0, out0[0]}, 32'b00);
    chk("slt_s", {30'd0, cond1, out1[0]}, 32'b11);

    issue(OpMul, 8'd13, 8'd11);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", {30'd0, busy0, rdy0}, 32'b10);
      step(1);
    end
    chk("mul_done", {30'd0, busy0, ov0}, 32'b01);
    chk("mul_out", {24'd0, out0}, 32'h8F);
    step(1);
    issue(OpMul, 8'd20, 8'd20);
    step(8);
    chk("mul2_out", {23'd0, carry0, out0}, 32'h190);
    step(1);

    Out_Ready = 1'b0;
    issue(OpAdd, 8'd1, 8'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {16'd0, out0, ov0, rdy0, carry0, zero0, err0, 3'd0}, {16'd0, 8'h03, 8'h80});
      step(1);
    end
    Out_Ready = 1'b1;
    issue(OpXor, 8'h5A, 8'h0F);
    chk("bp_xor", {23'd0, ov0, out0}, 32'h155);

    issue(OpLsh, 8'h81, 8'd1);
    chk("lsh", {24'd0, out0}, 32'h02);
    issue(OpRsh, 8'h81, 8'd8);
    chk("rsh_big", {24'd0, out0}, 32'h00);
    issue(4'hF, 8'h12, 8'h34);
    chk("illegal", {20'd0, out0, err0, zero0, carry0, cond1}, {20'd0, 8'h00, 4'b1101});
    issue(OpAdd, 8'h01, 8'h01);
    chk("err_clear", {31'd0, err0}, 32'd0);

    step(1);
    issue(OpMul, 8'd3, 8'd5);
    step(3);
    Reset_n = 1'b0;
    step(1);
    Reset_n = 1'b1;
    sb.delete();
    cm0 = 1'b0;
    cm1 = 1'b0;
    chk("mul_abort", {24'd0, ov0, busy0, rdy0, cond0, carry0, zero0, err0, cond1},
        32'b0010_0000);
    chk("mul_abort_out", {24'd0, out0}, 32'd0);
    step(8);
    chk("mul_abort_quiet", {30'd0, ov0, busy0}, 32'd0);
    issue(OpAdd, 8'h22, 8'h11);
    chk("post_rst_add", {23'd0, ov0, out0}, 32'h133);

    for (int n = 0; n < 20 && sb.size() != 0; n++) step(1);
    chk("sb_drain", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
